// File: rtl/yd_pkg.sv
// Shared constants and state encodings for the UART program loader.
package yd_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DAT_LO,
        ST_DAT_HI
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 serial byte receiver: two-flop synchroniser, mid-bit sampling, glitch-rejecting start detect.
module uart_rx_byte
    import yd_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLK_DIV - 1);

    logic        sync1_q, sync2_q, prev_q;
    rx_state_e   state_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        valid_q, ferr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (prev_q && !sync2_q) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    // Line back high at mid-start means it was a glitch, not a frame.
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        state_q <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= RX_STOP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        valid_q <= sync2_q;
                        ferr_q  <= !sync2_q;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = ferr_q;
endmodule

// File: rtl/uart_prog_loader.sv
// Loads a little-endian length-prefixed 16-bit word image from UART into instruction memory.
module uart_prog_loader
    import yd_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16,
    parameter int unsigned ROM_AW  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              i_we,
    output logic [ROM_AW-1:0] i_waddr,
    output logic [15:0]       i_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err
);
    localparam logic [16:0] MAX_WORDS = 17'(1) << ROM_AW;

    logic       rx_valid, rx_ferr;
    logic [7:0] rx_data;

    uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (uart_rx),
        .byte_valid(rx_valid),
        .byte_data (rx_data),
        .frame_err (rx_ferr)
    );

    ld_state_e         state_q;
    logic [7:0]        len_lo_q, lo_q;
    logic [15:0]       rem_q;
    logic [ROM_AW-1:0] addr_q, waddr_q;
    logic [15:0]       wdata_q;
    logic              we_q, hold_q, done_q, err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            len_lo_q <= '0;
            lo_q     <= '0;
            rem_q    <= '0;
            addr_q   <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (rx_ferr) begin
                state_q <= ST_IDLE;
                hold_q  <= 1'b0;
                err_q   <= 1'b1;
            end else if (rx_valid) begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            state_q <= ST_LEN_LO;
                            hold_q  <= 1'b1;
                            addr_q  <= '0;
                        end
                    end
                    ST_LEN_LO: begin
                        len_lo_q <= rx_data;
                        state_q  <= ST_LEN_HI;
                    end
                    ST_LEN_HI: begin
                        rem_q <= {rx_data, len_lo_q};
                        if ({rx_data, len_lo_q} == 16'd0) begin
                            state_q <= ST_IDLE;
                            hold_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if ({1'b0, rx_data, len_lo_q} > MAX_WORDS) begin
                            state_q <= ST_IDLE;
                            hold_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= ST_DAT_LO;
                        end
                    end
                    ST_DAT_LO: begin
                        lo_q    <= rx_data;
                        state_q <= ST_DAT_HI;
                    end
                    ST_DAT_HI: begin
                        we_q    <= 1'b1;
                        waddr_q <= addr_q;
                        wdata_q <= {rx_data, lo_q};
                        addr_q  <= addr_q + ROM_AW'(1);
                        rem_q   <= rem_q - 16'd1;
                        // Last word: release the core in the same cycle as the write.
                        if (rem_q == 16'd1) begin
                            state_q <= ST_IDLE;
                            hold_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DAT_LO;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        hold_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign i_we      = we_q;
    assign i_waddr   = waddr_q;
    assign i_wdata   = wdata_q;
    assign core_hold = hold_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with CLK_DIV=4, ROM_AW=4.
module tb_uart_prog_loader;
    localparam int CLK_DIV = 4;
    localparam int ROM_AW  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        uart_rx = 1'b1;
    logic        i_we;
    logic [3:0]  i_waddr;
    logic [15:0] i_wdata;
    logic        core_hold, done, err;

    always #5 clk = ~clk;

    uart_prog_loader #(.CLK_DIV(CLK_DIV), .ROM_AW(ROM_AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .i_we     (i_we),
        .i_waddr  (i_waddr),
        .i_wdata  (i_wdata),
        .core_hold(core_hold),
        .done     (done),
        .err      (err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int          we_cnt = 0, done_cnt = 0, err_cnt = 0, hold_rise = 0, done_on_fall = 0, both_cnt = 0;
    logic [3:0]  we_addr [16];
    logic [15:0] we_data [16];
    logic        hold_prev = 1'b0;

    always @(negedge clk) begin
        if (i_we) begin
            if (we_cnt < 16) begin
                we_addr[we_cnt] = i_waddr;
                we_data[we_cnt] = i_wdata;
            end
            we_cnt++;
        end
        if (done) begin
            done_cnt++;
            if (hold_prev && !core_hold) done_on_fall++;
        end
        if (err) err_cnt++;
        if (done && err) both_cnt++;
        if (core_hold && !hold_prev) hold_rise++;
        hold_prev = core_hold;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_mon();
        @(posedge clk);
        we_cnt = 0; done_cnt = 0; err_cnt = 0; hold_rise = 0; done_on_fall = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        uart_rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CLK_DIV) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);
    endtask

    task automatic settle();
        repeat (20) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_we", i_we, 0);
        check_eq("rst_waddr", i_waddr, 0);
        check_eq("rst_wdata", i_wdata, 0);
        check_eq("rst_hold", core_hold, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        $display("reset released");

        // Two-word load
        clear_mon();
        send_byte(8'hA5);
        check_eq("t1_hold_len", core_hold, 1);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h78); send_byte(8'h56);
        settle();
        check_eq("t1_we_cnt", we_cnt, 2);
        check_eq("t1_addr0", we_addr[0], 0);
        check_eq("t1_data0", we_data[0], 16'h1234);
        check_eq("t1_addr1", we_addr[1], 1);
        check_eq("t1_data1", we_data[1], 16'h5678);
        check_eq("t1_done", done_cnt, 1);
        check_eq("t1_err", err_cnt, 0);
        check_eq("t1_hold_rise", hold_rise, 1);
        check_eq("t1_done_on_fall", done_on_fall, 1);
        check_eq("t1_hold_end", core_hold, 0);
        check_eq("t1_waddr_hold", i_waddr, 1);
        check_eq("t1_wdata_hold", i_wdata, 16'h5678);
        $display("load A5 02 00 34 12 78 56: writes=%0d done=%0d", we_cnt, done_cnt);

        // Junk before sync, zero length
        clear_mon();
        send_byte(8'h11); send_byte(8'h22);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        settle();
        check_eq("t2_we_cnt", we_cnt, 0);
        check_eq("t2_done", done_cnt, 1);
        check_eq("t2_err", err_cnt, 0);
        check_eq("t2_hold_rise", hold_rise, 1);
        check_eq("t2_done_on_fall", done_on_fall, 1);
        $display("load 11 22 A5 00 00: writes=%0d done=%0d", we_cnt, done_cnt);

        // Length 17 exceeds 16-word memory
        clear_mon();
        send_byte(8'hA5); send_byte(8'h11); send_byte(8'h00);
        settle();
        check_eq("t3_err", err_cnt, 1);
        check_eq("t3_done", done_cnt, 0);
        check_eq("t3_we_cnt", we_cnt, 0);
        check_eq("t3_hold", core_hold, 0);
        $display("load A5 11 00: err=%0d", err_cnt);

        // Length 16 is the largest accepted; abort it with a framing error
        clear_mon();
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00);
        check_eq("t4_len16_hold", core_hold, 1);
        check_eq("t4_len16_err", err_cnt, 0);
        send_byte(8'h5A, 1'b0);
        settle();
        check_eq("t4_ferr_err", err_cnt, 1);
        check_eq("t4_ferr_hold", core_hold, 0);
        $display("load A5 10 00 + bad stop: err=%0d", err_cnt);

        // Framing error mid-load, then a clean load
        clear_mon();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h77, 1'b0);
        settle();
        check_eq("t5_err", err_cnt, 1);
        check_eq("t5_hold", core_hold, 0);
        check_eq("t5_we_cnt", we_cnt, 0);
        clear_mon();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hCD); send_byte(8'hAB);
        settle();
        check_eq("t5_we_cnt2", we_cnt, 1);
        check_eq("t5_addr", we_addr[0], 0);
        check_eq("t5_data", we_data[0], 16'hABCD);
        check_eq("t5_done", done_cnt, 1);
        $display("load after framing error: writes=%0d data=0x%0h", we_cnt, we_data[0]);

        // One-cycle glitch in idle
        clear_mon();
        @(negedge clk); uart_rx = 1'b0;
        @(negedge clk); uart_rx = 1'b1;
        settle();
        check_eq("t6_we_cnt", we_cnt, 0);
        check_eq("t6_err", err_cnt, 0);
        check_eq("t6_done", done_cnt, 0);
        check_eq("t6_hold_rise", hold_rise, 0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE);
        settle();
        check_eq("t6_we_after", we_cnt, 1);
        check_eq("t6_data_after", we_data[0], 16'hBEEF);
        $display("glitch then load: writes=%0d data=0x%0h", we_cnt, we_data[0]);

        // Reset during the DAT_HI byte
        clear_mon();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h78);
        uart_rx = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("t7_hold_pre", core_hold, 1);
        check_eq("t7_we_pre", we_cnt, 1);
        #1 rst = 1'b0;
        #1;
        check_eq("t7_rst_we", i_we, 0);
        check_eq("t7_rst_waddr", i_waddr, 0);
        check_eq("t7_rst_wdata", i_wdata, 0);
        check_eq("t7_rst_hold", core_hold, 0);
        check_eq("t7_rst_done", done, 0);
        check_eq("t7_rst_err", err, 0);
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        clear_mon();
        send_byte(8'h56); send_byte(8'h78); send_byte(8'h56);
        settle();
        check_eq("t7_post_we", we_cnt, 0);
        check_eq("t7_post_done", done_cnt, 0);
        check_eq("t7_post_hold", core_hold, 0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        settle();
        check_eq("t7_new_we", we_cnt, 1);
        check_eq("t7_new_addr", we_addr[0], 0);
        check_eq("t7_new_data", we_data[0], 16'h2211);
        $display("reset mid-load then new load: writes=%0d data=0x%0h", we_cnt, we_data[0]);

        check_eq("done_err_overlap", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, meaning clk cycles per UART bit (legal range 4..65535).
REQ-002 SHALL have parameter ROM_AW, default 10, meaning instruction-memory word-address width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port uart_rx  input  1  serial input, 8N1, LSB first, idle high, asynchronous to clk.
REQ-006 SHALL have port i_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-007 SHALL have port i_waddr  output  ROM_AW  instruction-memory word address.
REQ-008 SHALL have port i_wdata  output  16  instruction word.
REQ-009 SHALL have port core_hold  output  1  high while a load is in progress; ORed into the core reset by the SoC.
REQ-010 SHALL have port done  output  1  one-cycle pulse on successful load completion.
REQ-011 SHALL have port err  output  1  one-cycle pulse on framing or length error.

Function
REQ-012 SHALL synchronise uart_rx through two flops before any use.
REQ-013 SHALL detect a start bit on a high-to-low transition of the synchronised line, re-sample at CLK_DIV/2 and abort to idle if the line is high again (glitch).
REQ-014 SHALL sample each data bit and the stop bit every CLK_DIV cycles from the mid-start sample point.
REQ-015 SHALL emit a one-cycle byte-valid after a stop bit of 1; a stop bit of 0 SHALL discard the byte, pulse err and return the loader FSM to IDLE.
REQ-016 Loader FSM states SHALL be IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI.
REQ-017 IDLE: ignore every byte except 0xA5; on 0xA5 -> LEN_LO, assert core_hold, clear word address to 0.
REQ-018 LEN_LO/LEN_HI SHALL capture a 16-bit little-endian word count N.
REQ-019 On leaving LEN_HI: N=0 -> IDLE with done pulse; N > 2**ROM_AW -> IDLE with err pulse; otherwise -> DAT_LO.
REQ-020 DAT_LO SHALL latch the low byte and go to DAT_HI; DAT_HI SHALL present i_wdata={hi,lo}, i_waddr=current address, and assert i_we for exactly one cycle, starting the cycle after the byte-valid.
REQ-021 After each write the address SHALL increment by 1; after the Nth word the FSM SHALL go to IDLE and pulse done in the same cycle core_hold falls.
REQ-022 core_hold SHALL be low in IDLE and high in all other states; it SHALL fall in the cycle the FSM returns to IDLE.
REQ-023 A 0xA5 byte received outside IDLE SHALL be treated as data, not a resync.
REQ-024 i_waddr and i_wdata SHALL hold their last values when i_we is low.
REQ-025 done and err SHALL never be asserted in the same cycle.

Reset
REQ-026 On rst low: receiver idle, FSM IDLE, i_we=0, i_waddr=0, i_wdata=0, core_hold=0, done=0, err=0, bit/baud counters 0, synchroniser flops 1.
REQ-027 Reset asserted mid-byte or mid-load SHALL abandon the load with no further i_we; a partially written image is not rolled back.

Structure
REQ-028 Sync byte 0xA5 and FSM state encodings SHALL live in the shared package yd_pkg.
REQ-029 The serial receiver SHALL be a sub-module uart_rx_byte (clk, rst, rx, byte_valid, byte_data, frame_err); the loader FSM SHALL be in uart_prog_loader.

Verification (CLK_DIV=4, ROM_AW=4)
REQ-030 Send A5 02 00 34 12 78 56 -> i_we at addr 0 data 0x1234, then addr 1 data 0x5678, done pulse, core_hold high from LEN_LO entry to done.
REQ-031 Send 11 22 A5 00 00 -> no i_we, core_hold pulses only during the length phase, single done pulse.
REQ-032 Send A5 11 00 -> err pulse (17 > 16), FSM IDLE, no i_we.
REQ-033 Send A5 01 00 then a byte with stop bit 0 -> err pulse, core_hold falls, no i_we; a subsequent A5 01 00 CD AB writes 0xABCD to addr 0.
REQ-034 Drive a 1-cycle low glitch on uart_rx in IDLE -> no byte-valid, no state change.
REQ-035 Assert rst during the DAT_HI byte -> all outputs at reset values within the same cycle, no i_we after release until a new A5.
